// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem request at a time,
// and buffers {pc, instr} pairs in a small FIFO for decode. A redirect flushes everything.
module if_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   output logic                     imem_req_o,
   output logic [31:0]              imem_addr_o,
   input  logic                     imem_gnt_i,
   input  logic                     imem_rvalid_i,
   input  logic [31:0]              imem_rdata_i,
   output logic                     instr_valid_o,
   output logic [31:0]              instr_o,
   output logic [31:0]              instr_pc_o,
   input  logic                     instr_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t          state_reg, state_next;
   logic [31:0]     fetch_pc_reg, fetch_pc_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
   logic            push, pop, refill;

   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     pc_mem    [DEPTH];

   always_comb begin
      push          = (state_reg == WAIT) && imem_rvalid_i && !redirect_i;
      pop           = (count_reg != '0) && instr_ready_i && !redirect_i;
      count_next    = count_reg + CW'(push) - CW'(pop);
      refill        = start_i && (count_next < CW'(DEPTH));
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;

      case (state_reg)
         IDLE: if (start_i && (count_reg < CW'(DEPTH))) state_next = REQ;
         REQ:  if (imem_gnt_i) state_next = WAIT;
         WAIT: if (imem_rvalid_i) begin
                  fetch_pc_next = fetch_pc_reg + 32'd4;
                  state_next    = refill ? REQ : IDLE;
               end
         DROP: if (imem_rvalid_i) state_next = refill ? REQ : IDLE;
         default: state_next = IDLE;
      endcase

      // Redirect empties the FIFO, so any refill decision only depends on start_i.
      // A response landing in the redirect cycle itself closes the transaction.
      if (redirect_i) begin
         count_next    = '0;
         fetch_pc_next = redirect_pc_i & 32'hFFFF_FFFC;
         case (state_reg)
            IDLE:       state_next = start_i ? REQ : IDLE;
            REQ:        state_next = imem_gnt_i ? DROP : REQ;
            WAIT, DROP: state_next = imem_rvalid_i ? (start_i ? REQ : IDLE) : DROP;
            default:    state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         count_reg    <= '0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         count_reg    <= count_next;
         if (redirect_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
      end
   end

   // Entry storage carries no reset; the head is masked to zero while empty.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
               instr_mem[gi] <= imem_rdata_i;
               pc_mem[gi]    <= fetch_pc_reg;
            end
         end
      end
   endgenerate

   assign imem_req_o    = (state_reg == REQ);
   assign imem_addr_o   = fetch_pc_reg;
   assign instr_valid_o = (count_reg != '0);
   assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_reg] : 32'h0;
   assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_reg] : 32'h0;
   assign count_o       = count_reg;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: per-cycle vector table for streaming/backpressure,
// plus hand sequences for redirect, PC wrap and asynchronous reset.
module tb_if_prefetch_queue;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;
   logic [2:0]  count_o;

   logic        gnt_en = 1'b1;
   logic        rsp_en = 1'b1;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   int checks = 0;
   int errors = 0;

   if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_ready_i(instr_ready_i), .count_o(count_o)
   );

   initial forever #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // Memory: grants combinationally, answers one cycle after the grant when rsp_en is set.
   assign imem_gnt_i = imem_req_o & gnt_en;

   initial forever begin
      @(negedge clk_i);
      if (imem_req_o && imem_gnt_i) begin
         pend      = 1'b1;
         pend_addr = imem_addr_o;
      end
      @(posedge clk_i);
      #2;
      if (pend && rsp_en) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(pend_addr);
         pend          = 1'b0;
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = 32'h0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end else begin
         $display("check %s: ok (%0h)", name, got);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      start_i = 1'b0;
      instr_ready_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 32'h0;
      gnt_en = 1'b1;
      rsp_en = 1'b1;
      pend = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   function automatic logic [100:0] expect_vec(input logic rq, input logic [31:0] a, input logic v,
                                               input logic [31:0] p, input logic [2:0] c);
      return {rq, a, v, (v ? mem_word(p) : 32'h0), (v ? p : 32'h0), c};
   endfunction

   function automatic logic [100:0] observed();
      return {imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o};
   endfunction

   typedef struct {
      logic        rst;
      logic        start;
      logic        ready;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic s, input logic rd, input logic rq,
                      input logic [31:0] a, input logic v, input logic [31:0] p, input logic [2:0] c);
      vec_t e;
      e.rst = r; e.start = s; e.ready = rd; e.req = rq;
      e.addr = a; e.valid = v; e.pc = p; e.cnt = c;
      vq.push_back(e);
   endtask

   initial begin
      logic found;

      // Streaming with ready high: one entry at most, addresses 0,4,8,...
      add(1, 1, 1, 0, 32'h0,  0, 32'h0, 3'd0);
      add(0, 1, 1, 1, 32'h0,  0, 32'h0, 3'd0);
      add(0, 1, 1, 0, 32'h0,  0, 32'h0, 3'd0);
      add(0, 1, 1, 1, 32'h4,  1, 32'h0, 3'd1);
      add(0, 1, 1, 0, 32'h4,  0, 32'h0, 3'd0);
      add(0, 1, 1, 1, 32'h8,  1, 32'h4, 3'd1);
      add(0, 1, 1, 0, 32'h8,  0, 32'h0, 3'd0);
      add(0, 1, 1, 1, 32'hC,  1, 32'h8, 3'd1);
      // Backpressure: fill to 4, stop requesting, one pop reopens a single fetch at 16
      add(1, 1, 0, 0, 32'h0,  0, 32'h0, 3'd0);
      add(0, 1, 0, 1, 32'h0,  0, 32'h0, 3'd0);
      add(0, 1, 0, 0, 32'h0,  0, 32'h0, 3'd0);
      add(0, 1, 0, 1, 32'h4,  1, 32'h0, 3'd1);
      add(0, 1, 0, 0, 32'h4,  1, 32'h0, 3'd1);
      add(0, 1, 0, 1, 32'h8,  1, 32'h0, 3'd2);
      add(0, 1, 0, 0, 32'h8,  1, 32'h0, 3'd2);
      add(0, 1, 0, 1, 32'hC,  1, 32'h0, 3'd3);
      add(0, 1, 0, 0, 32'hC,  1, 32'h0, 3'd3);
      add(0, 1, 0, 0, 32'h10, 1, 32'h0, 3'd4);
      add(0, 1, 0, 0, 32'h10, 1, 32'h0, 3'd4);
      add(0, 1, 1, 0, 32'h10, 1, 32'h0, 3'd4);
      add(0, 1, 0, 0, 32'h10, 1, 32'h4, 3'd3);
      add(0, 1, 0, 1, 32'h10, 1, 32'h4, 3'd3);
      add(0, 1, 0, 0, 32'h10, 1, 32'h4, 3'd3);
      add(0, 1, 0, 0, 32'h14, 1, 32'h4, 3'd4);

      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].rst) do_reset();
         start_i       = vq[i].start;
         instr_ready_i = vq[i].ready;
         @(negedge clk_i);
         chk($sformatf("vec%0d", i), 128'(observed()),
             128'(expect_vec(vq[i].req, vq[i].addr, vq[i].valid, vq[i].pc, vq[i].cnt)));
         cyc();
      end

      // Redirect while waiting with two entries buffered; the late response is dropped
      do_reset();
      start_i = 1'b1;
      repeat (5) cyc();
      rsp_en = 1'b0;
      cyc();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      @(negedge clk_i);
      chk("redir_wait_pre_count", 128'(count_o), 128'd2);
      cyc();
      redirect_i = 1'b0;
      rsp_en = 1'b1;
      @(negedge clk_i);
      chk("redir_wait_flush", 128'({instr_valid_o, count_o, imem_req_o}), 128'({1'b0, 3'd0, 1'b0}));
      cyc();
      @(negedge clk_i);
      chk("redir_wait_next_req", 128'({imem_req_o, imem_addr_o, count_o}), 128'({1'b1, 32'h100, 3'd0}));
      cyc();
      cyc();
      @(negedge clk_i);
      chk("redir_wait_first_entry", 128'(observed()), 128'(expect_vec(1'b1, 32'h104, 1'b1, 32'h100, 3'd1)));

      // Redirect in the same cycle as rvalid and a pop
      do_reset();
      start_i = 1'b1;
      repeat (4) cyc();
      instr_ready_i = 1'b1;
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      @(negedge clk_i);
      chk("redir_rvalid_pre", 128'({count_o, imem_rvalid_i}), 128'({3'd1, 1'b1}));
      cyc();
      redirect_i = 1'b0;
      instr_ready_i = 1'b0;
      @(negedge clk_i);
      chk("redir_rvalid_flush", 128'({imem_req_o, imem_addr_o, instr_valid_o, count_o}),
          128'({1'b1, 32'h200, 1'b0, 3'd0}));
      cyc();
      cyc();
      @(negedge clk_i);
      chk("redir_rvalid_entry", 128'({instr_pc_o, instr_o, count_o}),
          128'({32'h200, mem_word(32'h200), 3'd1}));

      // PC wrap: 0xFFFFFFFC then 0x00000000
      do_reset();
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFE;
      cyc();
      redirect_i = 1'b0;
      start_i = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk_i);
         if (count_o == 3'd2) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      chk("wrap_fill", 128'(found), 128'd1);
      chk("wrap_first", 128'({instr_pc_o, instr_o}), 128'({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}));
      instr_ready_i = 1'b1;
      cyc();
      instr_ready_i = 1'b0;
      @(negedge clk_i);
      chk("wrap_second", 128'({instr_pc_o, instr_o}), 128'({32'h0, mem_word(32'h0)}));

      // Asynchronous reset while requesting with three entries held
      do_reset();
      start_i = 1'b1;
      repeat (7) cyc();
      gnt_en = 1'b0;
      @(negedge clk_i);
      chk("areset_pre", 128'({imem_req_o, count_o}), 128'({1'b1, 3'd3}));
      #2;
      rst_i = 1'b0;
      #1;
      chk("areset_outputs", 128'(observed()), 128'(expect_vec(1'b0, 32'h0, 1'b0, 32'h0, 3'd0)));
      pend = 1'b0;
      gnt_en = 1'b1;
      cyc();
      rst_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         if (imem_req_o) break;
         cyc();
      end
      chk("areset_first_req", 128'({imem_req_o, imem_addr_o}), 128'({1'b1, 32'h0}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
